// File: rtl/logic_pipe_pkg.sv
// logic_pipe_pkg: shared types and the bitwise operation used by logic_pipe.
//   op_e     : 2-bit operation select (AND / OR / XOR / NAND)
//   apply_op : single-bit result of op on (a, b); the caller applies it per bit
//              so the same function serves any operand width.
package logic_pipe_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_NAND = 2'b11
    } op_e;

    function automatic logic apply_op(input logic a, input logic b, input op_e op);
        logic r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NAND: r = ~(a & b);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/logic_pipe_stage.sv
// logic_pipe_stage: one register slice of the handshake pipeline.
//   clk_i, rst_ni       : clock, asynchronous active-low reset
//   valid_i, data_i     : upstream valid and data
//   ready_o             : this slice advances this cycle
//   valid_o, data_o     : registered valid and data
//   ready_i             : downstream slice (or consumer) advances this cycle
module logic_pipe_stage #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             ready_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    input  logic             ready_i
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             en;

    // An empty slice always advances, which is what collapses bubbles.
    assign en = !valid_q || ready_i;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (en) begin
            valid_d = valid_i;
            // Data only moves with a valid token, so an idle cycle leaves it untouched.
            if (valid_i) begin
                data_d = data_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign ready_o = en;
    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/logic_pipe.sv
// logic_pipe: bitwise AND/OR/XOR/NAND of two operands carried through a
// STAGES-deep valid/ready pipeline, with a count of delivered results.
//   clk_i, rst_ni     : clock, asynchronous active-low reset
//   valid_i, ready_o  : input handshake
//   a_i, b_i, op_i    : operands and operation select (op_e)
//   valid_o, ready_i  : output handshake
//   q_o               : result
//   count_o           : results delivered since reset, wrapping
module logic_pipe
    import logic_pipe_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [1:0]       op_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] q_o,
    output logic [CNT_W-1:0] count_o
);

    // Index k is the input side of stage k; index STAGES is the pipeline output.
    logic [STAGES:0]  vld;
    logic [STAGES:0]  rdy;
    logic [WIDTH-1:0] dat [STAGES+1];
    logic [WIDTH-1:0] res;

    always_comb begin
        res = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            res[i] = apply_op(a_i[i], b_i[i], op_e'(op_i));
        end
    end

    assign vld[0]      = valid_i;
    assign dat[0]      = res;
    assign rdy[STAGES] = ready_i;

    for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
        logic_pipe_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .valid_i (vld[k]),
            .data_i  (dat[k]),
            .ready_o (rdy[k]),
            .valid_o (vld[k+1]),
            .data_o  (dat[k+1]),
            .ready_i (rdy[k+1])
        );
    end

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (vld[STAGES] && ready_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign ready_o = rdy[0];
    assign valid_o = vld[STAGES];
    assign q_o     = dat[STAGES];
    assign count_o = count_q;

endmodule

// File: tb/tb_logic_pipe.sv
module tb_logic_pipe;

    logic       clk;
    logic       rst_n;

    // Main instance: WIDTH=8, STAGES=2, CNT_W=8
    logic       valid_i, ready_o, valid_o, ready_i;
    logic [7:0] a, b, q;
    logic [1:0] op;
    logic [7:0] count;

    // Second instance: STAGES=1, CNT_W=2
    logic       valid2_i, ready2_o, valid2_o, ready2_i;
    logic [7:0] a2, b2, q2;
    logic [1:0] op2;
    logic [1:0] count2;

    int n_assert = 0;
    int n_fail   = 0;

    logic_pipe #(.WIDTH(8), .STAGES(2), .CNT_W(8)) u_dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .a_i     (a),
        .b_i     (b),
        .op_i    (op),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .q_o     (q),
        .count_o (count)
    );

    logic_pipe #(.WIDTH(8), .STAGES(1), .CNT_W(2)) u_dut1 (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .valid_i (valid2_i),
        .ready_o (ready2_o),
        .a_i     (a2),
        .b_i     (b2),
        .op_i    (op2),
        .valid_o (valid2_o),
        .ready_i (ready2_i),
        .q_o     (q2),
        .count_o (count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    int exp_cnt[5];

    initial begin
        exp_cnt = '{1, 2, 3, 0, 1};
        rst_n = 1'b0;
        valid_i = 1'b0; ready_i = 1'b0; a = '0; b = '0; op = '0;
        valid2_i = 1'b0; ready2_i = 1'b0; a2 = '0; b2 = '0; op2 = '0;

        // Reset / idle
        tick(); tick();
        chk("rst_valid_o", valid_o, 0);
        chk("rst_q_o", q, 0);
        chk("rst_count_o", count, 0);
        chk("rst_ready_o", ready_o, 1);
        rst_n = 1'b1;
        tick();
        chk("idle_valid_o", valid_o, 0);
        chk("idle_q_o", q, 0);
        chk("idle_ready_o", ready_o, 1);

        // Streaming all four ops with ready_i=1
        ready_i = 1'b1; a = 8'hF0; b = 8'h3C;
        valid_i = 1'b1; op = 2'b00;
        tick();
        chk("stream_lat_valid", valid_o, 0);
        op = 2'b01;
        tick();
        chk("stream_and_v", valid_o, 1);
        chk("stream_and", q, 8'h30);
        op = 2'b10;
        tick();
        chk("stream_or", q, 8'hFC);
        op = 2'b11;
        tick();
        chk("stream_xor", q, 8'hCC);
        valid_i = 1'b0;
        tick();
        chk("stream_nand", q, 8'hCF);
        chk("stream_nand_v", valid_o, 1);
        tick();
        chk("stream_drain_v", valid_o, 0);
        chk("stream_count", count, 4);

        // Backpressure fill
        ready_i = 1'b0; valid_i = 1'b1; op = 2'b00;
        settle();
        chk("bp_ready0", ready_o, 1);
        tick();
        op = 2'b01;
        settle();
        chk("bp_ready1", ready_o, 1);
        tick();
        chk("bp_first_v", valid_o, 1);
        chk("bp_first_q", q, 8'h30);
        op = 2'b10;
        settle();
        chk("bp_full_ready", ready_o, 0);
        tick();
        chk("bp_hold_q", q, 8'h30);
        chk("bp_hold_v", valid_o, 1);
        chk("bp_hold_ready", ready_o, 0);
        ready_i = 1'b1;
        settle();
        chk("bp_pass_ready", ready_o, 1);
        tick();
        chk("bp_out1", q, 8'hFC);
        op = 2'b11;
        tick();
        chk("bp_out2", q, 8'hCC);
        valid_i = 1'b0;
        tick();
        chk("bp_out3", q, 8'hCF);
        chk("bp_out3_v", valid_o, 1);
        tick();
        chk("bp_empty_v", valid_o, 0);
        chk("bp_count", count, 8);

        // Bubble collapse with ready_i=0
        ready_i = 1'b0; valid_i = 1'b1; a = 8'hAA; b = 8'h0F; op = 2'b10;
        tick();
        valid_i = 1'b0;
        tick();
        chk("bub_first_v", valid_o, 1);
        chk("bub_first_q", q, 8'hA5);
        chk("bub_ready_gap", ready_o, 1);
        valid_i = 1'b1; op = 2'b01;
        settle();
        chk("bub_ready_accept", ready_o, 1);
        tick();
        valid_i = 1'b0;
        chk("bub_full_ready", ready_o, 0);
        chk("bub_hold_q", q, 8'hA5);
        ready_i = 1'b1;
        tick();
        chk("bub_second_q", q, 8'hAF);
        chk("bub_second_v", valid_o, 1);
        tick();
        chk("bub_empty_v", valid_o, 0);
        chk("bub_count", count, 10);

        // Reset with two results in flight
        ready_i = 1'b0; valid_i = 1'b1; a = 8'hFF; b = 8'h0F; op = 2'b00;
        tick();
        op = 2'b11;
        tick();
        valid_i = 1'b0;
        chk("mid_full_ready", ready_o, 0);
        rst_n = 1'b0;
        settle();
        chk("mid_rst_valid", valid_o, 0);
        chk("mid_rst_q", q, 0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_ready", ready_o, 1);
        tick();
        rst_n = 1'b1;
        ready_i = 1'b1;
        tick();
        chk("mid_post1_v", valid_o, 0);
        tick();
        chk("mid_post2_v", valid_o, 0);
        chk("mid_post_count", count, 0);

        // STAGES=1 instance: readiness and 2-bit counter wrap
        settle();
        chk("s1_idle_ready", ready2_o, 1);
        valid2_i = 1'b1; a2 = 8'h12; b2 = 8'h34; op2 = 2'b10;
        tick();
        chk("s1_v", valid2_o, 1);
        chk("s1_q", q2, 8'h26);
        chk("s1_full_ready", ready2_o, 0);
        ready2_i = 1'b1; op2 = 2'b00;
        settle();
        chk("s1_pass_ready", ready2_o, 1);
        for (int i = 0; i < 5; i++) begin
            if (i == 4) valid2_i = 1'b0;
            tick();
            chk($sformatf("wrap_count_%0d", i), count2, exp_cnt[i]);
            if (i == 0) chk("s1_q_and", q2, 8'h10);
        end
        chk("s1_drained_v", valid2_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
